add_neg_unit_32: RTL and testbench
==================================

Name: add_neg_unit_32

Overview:
- Registered 32-bit two's-complement arithmetic unit used by the datapath ALU.
- Provides ADD, SUB and NEG.
- SUB is built as: two's-complement negate of Rb, then a 32-bit add with carry-in.
- One-cycle latency; outputs are registered on the rising clock edge.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is required; all values below assume 32.

Ports:
- clock  in  1  system clock, rising-edge active
- clear  in  1  asynchronous active-low reset
- in_valid  in  1  operands, op and cin are valid this cycle
- op  in  2  00=ADD, 01=SUB, 10=NEG, 11=reserved
- Ra  in  32  operand A
- Rb  in  32  operand B
- cin  in  1  carry-in
- sum  out  32  registered result
- cout  out  1  registered carry-out
- ovf  out  1  registered signed-overflow flag
- out_valid  out  1  sum, cout and ovf are valid this cycle

Behaviour:
- Reset: clear=0 forces sum=0, cout=0, ovf=0 and out_valid=0 immediately, independent of clock. Registers stay in this state while clear is low.
- Capture: on each rising edge with clear=1, out_valid <= in_valid.
  - When in_valid=1, sum, cout and ovf are loaded from the combinational result.
  - When in_valid=0, sum, cout and ovf hold their previous values.
- Latency and throughput: result appears exactly 1 cycle after in_valid. A new operation is accepted every cycle. There is no backpressure.
- Negate definition: NEG(x) = (~x) + 1, mod 2^32. The carry of this increment is 1 only when x=0. NEG(0)=0 and NEG(0x80000000)=0x80000000.
- ADD: {cout,sum} = Ra + Rb + cin, computed at 33 bits.
- SUB: B' = NEG(Rb), then {cout,sum} = Ra + B' + cin at 33 bits.
  - cin is added, so cin=1 yields Ra-Rb+1.
  - cout is the carry of this final add only. The negate carry is discarded.
  - Consequence: when Rb≠0, cout=1 iff Ra>=Rb (unsigned), for cin=0. When Rb=0, cout=0 because B'=0.
- NEG: sum = NEG(Rb), cout = (Rb==0), cin ignored.
- Reserved op (11): sum=0, cout=0, ovf=0. out_valid still follows in_valid.
- ovf, ADD/SUB: 1 when both adder inputs (Ra and Rb, or Ra and B') have the same sign bit and sum's sign bit differs.
- ovf, NEG: 1 iff Rb=0x80000000.
- Wrap-around: all arithmetic is modulo 2^32. There is no saturation.
- Reset mid-operation: an in-flight result is discarded and out_valid=0. After clear deasserts, the first edge with in_valid=1 produces a valid result on the next cycle.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_NEG=2'b10, OP_RSV=2'b11
  - WIDTH constant 32
- Two combinational sub-modules, instantiated by the top:
  - adder32_core: 32-bit ripple or carry-lookahead adder with inputs a, b, ci and outputs s, co.
  - negate32_core: invert plus increment, using its own adder32_core instance or an incrementer.
- The top contains only op muxing, overflow logic and the output registers.

Test Plan:
- Reset: hold clear=0 with random inputs and in_valid=1 -> sum=0, cout=0, ovf=0, out_valid=0. Assert clear=0 mid-stream -> outputs go to 0 before the next edge.
- SUB with cin=0 (one result per cycle, each 1 cycle after its input):
  - Ra=1, Rb=1 -> sum=0, cout=1, ovf=0
  - Ra=235, Rb=35 -> sum=200, cout=1
  - Ra=20, Rb=25 -> sum=0xFFFFFFFB (-5), cout=0
- SUB edge cases:
  - Ra=5, Rb=0, cin=0 -> sum=5, cout=0
  - Ra=0x80000000, Rb=1, cin=0 -> sum=0x7FFFFFFF, ovf=1
  - Ra=7, Rb=3, cin=1 -> sum=5
- ADD:
  - Ra=0xFFFFFFFF, Rb=1, cin=0 -> sum=0, cout=1, ovf=0
  - Ra=0x7FFFFFFF, Rb=0, cin=1 -> sum=0x80000000, ovf=1
  - Ra=999, Rb=1, cin=0 -> sum=1000
- NEG:
  - Rb=0 -> sum=0, cout=1
  - Rb=1 -> sum=0xFFFFFFFF, cout=0
  - Rb=0x80000000 -> sum=0x80000000, ovf=1
  - cin=1 has no effect on NEG
- Valid and hold:
  - Alternate in_valid 1/0 -> out_valid mirrors it with 1-cycle delay, and sum holds during idle cycles.
  - op=11 -> sum=0, cout=0.
  - Back-to-back random ADD/SUB operations checked against a 33-bit reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the add/negate arithmetic unit:
// datapath width and the 2-bit operation encodings.
package alu_pkg;

   localparam int WIDTH = 32;
   localparam int MSB   = WIDTH - 1;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_NEG = 2'b10,
      OP_RSV = 2'b11
   } op_e;

endpackage

// File: rtl/add_neg_unit_32_if.sv
// Operand/result bundle of the add/negate unit.
// master drives in_valid/op/Ra/Rb/cin; slave returns sum/cout/ovf/out_valid.
interface add_neg_unit_32_if;
   import alu_pkg::*;

   logic             in_valid;
   logic [1:0]       op;
   logic [WIDTH-1:0] Ra;
   logic [WIDTH-1:0] Rb;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             out_valid;

   modport master (
      output in_valid, op, Ra, Rb, cin,
      input  sum, cout, ovf, out_valid
   );

   modport slave (
      input  in_valid, op, Ra, Rb, cin,
      output sum, cout, ovf, out_valid
   );

endinterface

// File: rtl/adder32_core.sv
// Combinational 32-bit adder with carry-in.
// Ports: a, b operands; ci carry-in; s sum; co carry-out.
module adder32_core
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   logic [WIDTH:0] t;

   assign t       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
   assign {co, s} = t;

endmodule

// File: rtl/negate32_core.sv
// Two's-complement negate: y = ~x + 1 (mod 2^32).
// Ports: x_i operand; y_o result; co_o increment carry (1 only for x=0).
module negate32_core
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] x_i,
   output logic [WIDTH-1:0] y_o,
   output logic             co_o
);

   logic [WIDTH-1:0] inv;
   logic [WIDTH-1:0] zero;

   assign inv  = ~x_i;
   assign zero = '0;

   adder32_core u_inc (
      .a  (inv),
      .b  (zero),
      .ci (1'b1),
      .s  (y_o),
      .co (co_o)
   );

endmodule

// File: rtl/add_neg_unit_32.sv
// Registered ADD/SUB/NEG unit, one-cycle latency, no backpressure.
// Ports: clock, clear (async active-low), bus (slave side of the bundle).
module add_neg_unit_32
   import alu_pkg::*;
(
   input  logic               clock,
   input  logic               clear,
   add_neg_unit_32_if.slave   bus
);

   logic [WIDTH-1:0] neg_b;
   logic             neg_co;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_s;
   logic             add_co;

   logic [WIDTH-1:0] sum_d,  sum_q;
   logic             cout_d, cout_q;
   logic             ovf_d,  ovf_q;
   logic             vld_q;

   negate32_core u_neg (
      .x_i  (bus.Rb),
      .y_o  (neg_b),
      .co_o (neg_co)
   );

   // SUB feeds the negated Rb into the shared adder;
   // the negate carry is not part of the SUB carry-out.
   assign add_b = (bus.op == OP_SUB) ? neg_b : bus.Rb;

   adder32_core u_add (
      .a  (bus.Ra),
      .b  (add_b),
      .ci (bus.cin),
      .s  (add_s),
      .co (add_co)
   );

   always_comb begin
      sum_d  = '0;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
      unique case (bus.op)
         OP_ADD, OP_SUB: begin
            sum_d  = add_s;
            cout_d = add_co;
            // like-signed inputs producing an unlike-signed sum
            ovf_d  = (bus.Ra[MSB] == add_b[MSB]) &&
                     (add_s[MSB] != bus.Ra[MSB]);
         end
         OP_NEG: begin
            sum_d  = neg_b;
            cout_d = neg_co;
            // only the most negative value fails to negate
            ovf_d  = (bus.Rb == {1'b1, {MSB{1'b0}}});
         end
         OP_RSV: begin
            sum_d  = '0;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= bus.in_valid;
         if (bus.in_valid) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
         end
      end
   end

   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_add_neg_unit_32.sv
// Self-checking bench for add_neg_unit_32.
// Random and directed operations against a plain-arithmetic reference.
module tb_add_neg_unit_32;

   logic clock = 1'b0;
   logic clear = 1'b0;

   add_neg_unit_32_if bus ();

   add_neg_unit_32 dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // expected state: {ovf, cout, sum} and out_valid
   logic [33:0] exp_res = '0;
   logic        exp_vld = 1'b0;
   logic [34:0] got, want;

   function automatic logic [33:0] ref_op(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic c);
      logic [31:0] bb;
      logic [32:0] wide;
      longint      sv;
      longint      hi;
      longint      lo;
      logic        ov;
      hi = 64'sd2147483647;
      lo = -64'sd2147483648;
      case (o)
         2'b10: return {b == 32'h8000_0000, b == 32'd0, 32'd0 - b};
         2'b11: return '0;
         default: begin
            bb   = (o == 2'b01) ? 32'd0 - b : b;
            wide = {1'b0, a} + {1'b0, bb} + {32'd0, c};
            sv   = longint'($signed(a)) + longint'($signed(bb)) +
                   longint'(c);
            ov   = (sv > hi) || (sv < lo);
            return {ov, wide[32], wide[31:0]};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'h7FFF_FFFF;
         3: return 32'hFFFF_FFFF;
         4: return $urandom_range(0, 8);
         default: return $urandom;
      endcase
   endfunction

   // drive one cycle of stimulus and advance the reference
   task automatic apply(input logic v, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic c);
      @(negedge clock);
      bus.in_valid = v;
      bus.op       = o;
      bus.Ra       = a;
      bus.Rb       = b;
      bus.cin      = c;
      @(posedge clock);
      #1;
      exp_vld = v;
      if (v) exp_res = ref_op(o, a, b, c);
   endtask

   task automatic test_reset();
      clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.op       = 2'($urandom_range(0, 2));
         bus.Ra       = $urandom;
         bus.Rb       = $urandom;
         bus.cin      = 1'($urandom);
         @(posedge clock);
         #1;
         got = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
         total++;
         if (got !== 35'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", got, 35'd0);
         end
      end
      @(negedge clock);
      clear   = 1'b1;
      exp_res = '0;
      exp_vld = 1'b0;
      // make a non-zero valid result, then clear between edges
      apply(1'b1, 2'b00, 32'd999, 32'd1, 1'b0);
      got = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
      want = {exp_vld, exp_res};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL reset_pre got=%h exp=%h", got, want);
      end
      #2;
      clear = 1'b0;
      #1;
      got = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
      total++;
      if (got !== 35'd0) begin
         bad++;
         $display("FAIL reset_async got=%h exp=%h", got, 35'd0);
      end
      @(negedge clock);
      clear   = 1'b1;
      exp_res = '0;
      exp_vld = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      logic [31:0] s;
   } vec_t;

   // directed vectors with hand-derived sums, checked back to back
   task automatic test_directed();
      vec_t v [14];
      v[0]  = '{2'b01, 32'd1,          32'd1,          1'b0, 32'd0};
      v[1]  = '{2'b01, 32'd235,        32'd35,         1'b0, 32'd200};
      v[2]  = '{2'b01, 32'd20,         32'd25,         1'b0, 32'hFFFF_FFFB};
      v[3]  = '{2'b01, 32'd5,          32'd0,          1'b0, 32'd5};
      v[4]  = '{2'b01, 32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF};
      v[5]  = '{2'b01, 32'd7,          32'd3,          1'b1, 32'd5};
      v[6]  = '{2'b00, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0};
      v[7]  = '{2'b00, 32'h7FFF_FFFF,  32'd0,          1'b1, 32'h8000_0000};
      v[8]  = '{2'b00, 32'd999,        32'd1,          1'b0, 32'd1000};
      v[9]  = '{2'b10, 32'd77,         32'd0,          1'b0, 32'd0};
      v[10] = '{2'b10, 32'd3,          32'd1,          1'b0, 32'hFFFF_FFFF};
      v[11] = '{2'b10, 32'd0,          32'h8000_0000,  1'b0, 32'h8000_0000};
      v[12] = '{2'b10, 32'd0,          32'd5,          1'b1, 32'hFFFF_FFFB};
      v[13] = '{2'b11, 32'd9,          32'd4,          1'b1, 32'd0};
      foreach (v[i]) begin
         apply(1'b1, v[i].o, v[i].a, v[i].b, v[i].c);
         got  = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
         want = {exp_vld, exp_res};
         total++;
         if (got !== want || bus.sum !== v[i].s) begin
            bad++;
            $display("FAIL directed[%0d] got=%h exp=%h sum_exp=%h",
                     i, got, want, v[i].s);
         end
      end
   endtask

   task automatic test_valid_hold();
      for (int i = 0; i < 20; i++) begin
         apply(1'(i % 2 == 0), 2'($urandom_range(0, 3)),
               pick(), pick(), 1'($urandom));
         got  = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
         want = {exp_vld, exp_res};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL valid_hold[%0d] got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         apply(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               pick(), pick(), 1'($urandom));
         got  = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
         want = {exp_vld, exp_res};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL b2b[%0d] got=%h exp=%h", i, got, want);
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.op       = 2'b00;
      bus.Ra       = '0;
      bus.Rb       = '0;
      bus.cin      = 1'b0;
      test_reset();
      test_directed();
      test_valid_hold();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
